// File: rtl/alu_seq.sv
// Sequencer that issues ALU ops to a fixed-latency DSP-style datapath and
// collects the results in order into a credit-protected result FIFO.
`ifndef PORTAWIDTH
`define PORTAWIDTH 30
`endif
`ifndef PORTBWIDTH
`define PORTBWIDTH 18
`endif
`ifndef PORTCWIDTH
`define PORTCWIDTH 48
`endif
`ifndef PORTPWIDTH
`define PORTPWIDTH 48
`endif

module alu_seq #(
  parameter int LAT   = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_valid_i,
  output logic                   op_ready_o,
  input  logic [2:0]             op_i,
  input  logic [3:0]             tag_i,
  input  logic [`PORTAWIDTH-1:0] a_i,
  input  logic [`PORTBWIDTH-1:0] b_i,
  input  logic [`PORTCWIDTH-1:0] c_i,
  output logic [`PORTAWIDTH-1:0] a_o,
  output logic [`PORTBWIDTH-1:0] b_o,
  output logic [`PORTCWIDTH-1:0] c_o,
  output logic [6:0]             opmode_o,
  output logic [3:0]             alumode_o,
  output logic [4:0]             inmode_o,
  output logic                   usemult_o,
  output logic                   cea2_o,
  output logic                   ceb2_o,
  input  logic [`PORTPWIDTH-1:0] p_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [`PORTPWIDTH-1:0] res_data_o,
  output logic [3:0]             res_tag_o,
  output logic                   err_o,
  output logic                   idle_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PLAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CDEPTH = CW'(DEPTH);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_MADD = 3'd3;
  localparam logic [2:0] OP_MSUB = 3'd4;

  logic [CW-1:0] used_q;
  logic [CW-1:0] occ_q;
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;

  logic [`PORTPWIDTH-1:0] mem_q [DEPTH];
  logic [3:0]             tmem_q [DEPTH];

  logic           iss_v_q;
  logic [3:0]     iss_tag_q;
  logic [LAT-1:0] sr_v_q;
  logic [3:0]     sr_tag_q [LAT];

  logic [`PORTAWIDTH-1:0] a_q;
  logic [`PORTBWIDTH-1:0] b_q;
  logic [`PORTCWIDTH-1:0] c_q;
  logic [6:0]             opm_q;
  logic [3:0]             alu_q;
  logic                   mul_q;
  logic                   ce_q;
  logic                   err_q;

  logic [6:0] opm_d;
  logic [3:0] alu_d;
  logic       mul_d;
  logic       legal;
  logic       accept;
  logic       iss;
  logic       pop;
  logic       cap;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PLAST) ? '0 : p + 1'b1;
  endfunction

  assign legal  = (op_i <= OP_MSUB);
  assign accept = op_valid_i & op_ready_o & ~rst;
  assign iss    = accept & legal;
  assign pop    = res_valid_o & res_ready_i;
  assign cap    = sr_v_q[LAT-1] & ~rst;

  always_comb begin
    opm_d = '0;
    alu_d = '0;
    mul_d = 1'b0;
    unique case (1'b1)
      (op_i == OP_ADD):  opm_d = 7'h33;
      (op_i == OP_SUB):  begin opm_d = 7'h33; alu_d = 4'h3; end
      (op_i == OP_MUL):  begin opm_d = 7'h05; mul_d = 1'b1; end
      (op_i == OP_MADD): begin opm_d = 7'h35; mul_d = 1'b1; end
      (op_i == OP_MSUB): begin
        opm_d = 7'h35;
        alu_d = 4'h3;
        mul_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      used_q    <= '0;
      occ_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      iss_v_q   <= 1'b0;
      iss_tag_q <= '0;
      sr_v_q    <= '0;
      for (int i = 0; i < LAT; i++) sr_tag_q[i] <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      opm_q <= '0;
      alu_q <= '0;
      mul_q <= 1'b0;
      ce_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      iss_v_q   <= iss;
      iss_tag_q <= tag_i;
      err_q     <= accept & ~legal;
      a_q   <= iss ? a_i : '0;
      b_q   <= iss ? b_i : '0;
      c_q   <= iss ? c_i : '0;
      opm_q <= iss ? opm_d : '0;
      alu_q <= iss ? alu_d : '0;
      mul_q <= iss & mul_d;
      ce_q  <= iss;
      // stage i holds the op issued i+1 cycles ago
      sr_v_q[0]   <= iss_v_q;
      sr_tag_q[0] <= iss_tag_q;
      for (int i = 1; i < LAT; i++) begin
        sr_v_q[i]   <= sr_v_q[i-1];
        sr_tag_q[i] <= sr_tag_q[i-1];
      end
      if (cap) wptr_q <= nxt(wptr_q);
      if (pop) rptr_q <= nxt(rptr_q);
      if (cap & ~pop) occ_q <= occ_q + 1'b1;
      else if (~cap & pop) occ_q <= occ_q - 1'b1;
      if (iss & ~pop) used_q <= used_q + 1'b1;
      else if (~iss & pop) used_q <= used_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      mem_q[wptr_q]  <= p_i;
      tmem_q[wptr_q] <= sr_tag_q[LAT-1];
    end
  end

  assign op_ready_o  = rst | (used_q < CDEPTH);
  assign idle_o      = rst | (used_q == '0);
  assign res_valid_o = ~rst & (occ_q != '0);
  assign res_data_o  = res_valid_o ? mem_q[rptr_q] : '0;
  assign res_tag_o   = res_valid_o ? tmem_q[rptr_q] : '0;
  assign err_o       = ~rst & err_q;

  assign a_o       = rst ? '0 : a_q;
  assign b_o       = rst ? '0 : b_q;
  assign c_o       = rst ? '0 : c_q;
  assign opmode_o  = rst ? '0 : opm_q;
  assign alumode_o = rst ? '0 : alu_q;
  assign inmode_o  = '0;
  assign usemult_o = ~rst & mul_q;
  assign cea2_o    = ~rst & ce_q;
  assign ceb2_o    = ~rst & ce_q;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter LAT, default 4: cycles from an op appearing on the alu-side outputs to its result on p_i.
REQ-002 Parameter DEPTH, default 4: result buffer entries; DEPTH SHALL be >= LAT.
REQ-003 Port clk, input, 1: single clock; all logic on posedge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port op_valid_i, input, 1: request valid.
REQ-006 Port op_ready_o, output, 1: request accepted when op_valid_i && op_ready_o.
REQ-007 Port op_i, input, 3: 0 ADD, 1 SUB, 2 MUL, 3 MADD, 4 MSUB, 5-7 illegal.
REQ-008 Port tag_i, input, 4: request id, returned with the result.
REQ-009 Ports a_i, b_i, c_i, input, `PORTAWIDTH/`PORTBWIDTH/`PORTCWIDTH (30/18/48): operands.
REQ-010 Ports a_o, b_o, c_o, output, 30/18/48: operands to alu.
REQ-011 Ports opmode_o 7, alumode_o 4, inmode_o 5, usemult_o 1, cea2_o 1, ceb2_o 1, output: alu control.
REQ-012 Port p_i, input, `PORTPWIDTH (48): alu result.
REQ-013 Ports res_valid_o, output, 1 / res_ready_i, input, 1: result handshake.
REQ-014 Ports res_data_o 48 / res_tag_o 4, output: result payload.
REQ-015 Port err_o, output, 1: one-cycle pulse on illegal op acceptance.
REQ-016 Port idle_o, output, 1: high when nothing is in flight and the buffer is empty.

Function
REQ-017 The block SHALL set op_ready_o = (inflight + buffered < DEPTH), combinationally from registered state.
REQ-018 A legal accepted op in cycle t SHALL drive the registered alu-side outputs during cycle t+1 (issue cycle).
REQ-019 The issue-cycle encodings SHALL be:
- ADD: opmode 7'h33, alumode 4'h0, usemult 0
- SUB: opmode 7'h33, alumode 4'h3, usemult 0
- MUL: opmode 7'h05, alumode 4'h0, usemult 1
- MADD: opmode 7'h35, alumode 4'h0, usemult 1
- MSUB: opmode 7'h35, alumode 4'h3, usemult 1
- all ops: inmode 5'h00, cea2_o = ceb2_o = 1
REQ-020 In non-issue cycles, all alu-side outputs SHALL be 0.
REQ-021 An illegal op SHALL be accepted, SHALL NOT issue or consume credit, and SHALL pulse err_o in cycle t+1.
REQ-022 A LAT-deep valid/tag shift register SHALL capture p_i into the buffer exactly LAT cycles after the issue cycle.
REQ-023 The buffer SHALL be a DEPTH-entry FIFO with wrap-around read/write pointers and strictly in-order results.
REQ-024 The head SHALL drive res_data_o/res_tag_o, with res_valid_o = buffer not empty.
REQ-025 The head SHALL pop on res_valid_o && res_ready_i; res_data_o SHALL stay stable while stalled.
REQ-026 A capture and a pop in the same cycle SHALL leave the occupancy unchanged, including when the buffer is full.
REQ-027 An accept and a pop in the same cycle SHALL leave the credit count unchanged.
REQ-028 The credit accounting SHALL guarantee that a capture never finds the buffer full; no result SHALL ever be dropped.
REQ-029 Back-to-back accepts SHALL be supported at one per cycle while credit remains.

Reset
REQ-030 In a cycle with rst=1, all outputs SHALL go to 0 except op_ready_o=1 and idle_o=1.
REQ-031 Reset SHALL clear the pointers, occupancy, in-flight count and shift register.
REQ-032 Reset mid-operation SHALL discard in-flight and buffered results; p_i SHALL be ignored until new issues.

Verification
REQ-033 ADD with a=0, b=5, c=10, tag 3 -> issue shows opmode 33h, alumode 0; 4 cycles later res_data_o=15, tag 3.
REQ-034 MSUB with a=3, b=4, c=20 and a model alu -> opmode 35h, alumode 3h, usemult 1; result 8.
REQ-035 5 back-to-back ops with res_ready_i=0 -> 4 accepted, then op_ready_o=0; releasing res_ready_i drains all results in order, tags 0..3.
REQ-036 op_i=6 -> err_o pulses once, no issue, credit unchanged, idle_o stays 1.
REQ-037 Full buffer with simultaneous pop and accept for 20 cycles -> occupancy constant, no loss or duplication, pointers wrap.
REQ-038 rst asserted with 2 in flight and 2 buffered -> next cycle res_valid_o=0, idle_o=1, op_ready_o=1; late p_i values not captured.
